// File: rtl/mux_pkg.sv
// Shared types and constants for the N:1 stream mux and its helpers.
package mux_pkg;

  // IDLE: no channel owns the output. LOCK: grant_q owns it until last=1.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/mux_stream_nto1_rr_pick.sv
// Rotating priority encoder: first asserted req at or after ptr, wrapping.
// Pure combinational; ptr is expected to be < N_CH.
module rr_pick #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [N_CH-1:0] rot;
  logic [SEL_W:0]  sum;

  // Rotate req so ptr lands on bit 0, take the lowest set bit, map it back.
  always_comb begin
    rot     = N_CH'({req, req} >> ptr);
    sum     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      if (!gnt_any && rot[j]) begin
        gnt_any = 1'b1;
        sum     = {1'b0, ptr} + (SEL_W+1)'(j);
        if (sum >= (SEL_W+1)'(N_CH)) sum = sum - (SEL_W+1)'(N_CH);
        gnt_idx = sum[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_stream_nto1.sv
// Registered N:1 valid/ready stream mux with fixed-select or round-robin
// arbitration; a grant is held for a whole packet (until last=1 is taken).
module mux_stream_nto1 import mux_pkg::*; #(
  parameter  int N_CH  = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_last,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic [SEL_W-1:0]  out_ch,
  input  logic              out_ready
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;

  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic             fix_ok;
  logic [SEL_W-1:0] act;
  logic             act_ok;
  logic             act_v, act_l;
  logic [W-1:0]     act_d;
  logic             can_load;
  logic             xfer;

  rr_pick #(.N_CH(N_CH)) u_rr_pick (
    .req     (in_valid),
    .ptr     (rr_ptr_q),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Pick the active channel: the lock owner, else this cycle's candidate.
  // A sel beyond N_CH-1 matches no channel and so yields no candidate.
  always_comb begin
    fix_ok = 1'b0;
    for (int i = 0; i < N_CH; i++)
      if (sel == SEL_W'(i)) fix_ok = in_valid[i];
    if (state_q == LOCK) begin
      act    = grant_q;
      act_ok = 1'b1;
    end else if (mode == MODE_FIXED) begin
      act    = sel;
      act_ok = fix_ok;
    end else begin
      act    = rr_idx;
      act_ok = rr_any;
    end
  end

  assign can_load = !out_valid_q || out_ready;

  // Route ready to the active channel only and gather its beat.
  always_comb begin
    in_ready = '0;
    act_v    = 1'b0;
    act_l    = 1'b0;
    act_d    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (act == SEL_W'(i)) begin
        act_v = in_valid[i];
        act_l = in_last[i];
        act_d = in_data[i*W +: W];
        if (act_ok && can_load && !rst) in_ready[i] = 1'b1;
      end
    end
  end

  assign xfer = act_ok && act_v && can_load && !rst;

  // Next-state: load output on a transfer, drop valid when drained, and
  // track packet ownership plus the round-robin pointer on packet ends.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = act_d;
      out_last_d  = act_l;
      out_ch_d    = act;
      if (act_l) begin
        state_d = IDLE;
        if (act == SEL_W'(N_CH-1)) rr_ptr_d = '0;
        else                       rr_ptr_d = act + 1'b1;
      end else if (state_q == IDLE) begin
        state_d = LOCK;
        grant_d = act;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset wins over any in-flight packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Bench for mux_stream_nto1: directed scenarios plus random traffic against
// a packet-level reference model; a second 3-channel build covers bad sel.
module tb_mux_stream_nto1;

  localparam int N = 4;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mode = 1'b0;
  logic [1:0]    sel = '0;
  logic [N-1:0]  iv = '0, il = '0, irdy;
  logic [N*W-1:0] id = '0;
  logic          ov, ol;
  logic [W-1:0]  od;
  logic [1:0]    och;
  logic          ordy = 1'b1;

  logic [1:0]    sel3 = '0;
  logic [2:0]    iv3 = '0, il3 = '0, irdy3;
  logic [3*W-1:0] id3 = '0;
  logic          ov3, ol3;
  logic [W-1:0]  od3;
  logic [1:0]    och3;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: owner (-1 = none), round-robin pointer, output beat
  int         m_own = -1;
  int         m_ptr = 0;
  logic       m_ov  = 1'b0;
  logic [7:0] m_od  = '0;
  logic       m_ol  = 1'b0;
  int         m_och = 0;

  always #5 clk = ~clk;

  mux_stream_nto1 #(.N_CH(N), .W(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(iv), .in_data(id), .in_last(il), .in_ready(irdy),
    .out_valid(ov), .out_data(od), .out_last(ol), .out_ch(och),
    .out_ready(ordy)
  );

  mux_stream_nto1 #(.N_CH(3), .W(W)) dut3 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel3),
    .in_valid(iv3), .in_data(id3), .in_last(il3), .in_ready(irdy3),
    .out_valid(ov3), .out_data(od3), .out_last(ol3), .out_ch(och3),
    .out_ready(ordy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // channel that may move a beat this cycle, or -1
  function automatic int m_act();
    if (rst) return -1;
    if (m_own >= 0) return m_own;
    if (mode == 1'b0) return iv[sel] ? int'(sel) : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (iv[c]) return c;
    end
    return -1;
  endfunction

  // one clock: check ready before the edge, advance model, check outputs after
  task automatic cyc();
    int a;
    logic room, fire;
    logic [N-1:0] er;
    #1;
    a    = m_act();
    room = !m_ov || ordy;
    er   = '0;
    fire = 1'b0;
    if (a >= 0 && room) begin
      er[a] = 1'b1;
      fire  = iv[a];
    end
    chk("in_ready", 32'(irdy), 32'(er));
    @(posedge clk);
    if (rst) begin
      m_own = -1; m_ptr = 0; m_ov = 1'b0; m_od = '0; m_ol = 1'b0; m_och = 0;
    end else if (fire) begin
      m_ov  = 1'b1;
      m_od  = id[a*W +: W];
      m_ol  = il[a];
      m_och = a;
      if (il[a]) begin
        m_own = -1;
        m_ptr = (a + 1) % N;
      end else begin
        m_own = a;
      end
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    #1;
    chk("out_valid", 32'(ov), 32'(m_ov));
    chk("out_data", 32'(od), 32'(m_od));
    chk("out_last", 32'(ol), 32'(m_ol));
    chk("out_ch", 32'(och), 32'(m_och));
  endtask

  task automatic do_rst();
    rst = 1'b1; iv = '0; iv3 = '0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    do_rst();
    chk("rst_ov", 32'(ov), 0);
    chk("rst_od", 32'(od), 0);
    chk("rst_och", 32'(och), 0);

    // fixed select, single-beat packet on ch2
    mode = 1'b0; sel = 2'd2; iv = 4'b0100; il = 4'b0100; id = 32'h00A5_0000;
    ordy = 1'b1;
    cyc();
    chk("fix_ov", 32'(ov), 1);
    chk("fix_od", 32'(od), 32'hA5);
    chk("fix_och", 32'(och), 2);
    chk("fix_ol", 32'(ol), 1);
    chk("fix_rdy", 32'(irdy), 32'b0100);
    iv = '0; cyc();

    // round-robin fairness with wrap
    do_rst();
    mode = 1'b1; iv = 4'hF; il = 4'hF; id = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_ch", 32'(och), 32'(k % 4));
      chk("rr_data", 32'(od), 32'(8'h10 + k % 4));
    end
    iv = '0; cyc();

    // packet lock on ch1 while ch0/ch2 contend and sel toggles
    do_rst();
    mode = 1'b1; iv = 4'b0001; il = 4'hF; id = 32'h0022_2120;
    cyc();
    iv = 4'b0111; il = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      if (b == 2) il = 4'b0111;
      sel = 2'(b);
      cyc();
      chk("lock_ch", 32'(och), 1);
    end
    chk("lock_last", 32'(ol), 1);
    cyc();
    chk("lock_next", 32'(och), 2);
    iv = '0; cyc();

    // backpressure mid-packet
    do_rst();
    mode = 1'b0; sel = 2'd1; iv = 4'b0010; il = '0; id = 32'h0000_4200;
    cyc();
    ordy = 1'b0; id = 32'h0000_4300;
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk("bp_hold", 32'(od), 32'h42);
      chk("bp_rdy", 32'(irdy), 0);
    end
    ordy = 1'b1;
    cyc();
    chk("bp_next", 32'(od), 32'h43);
    il = 4'b0010; id = 32'h0000_4400;
    cyc();
    chk("bp_end", 32'(od), 32'h44);
    iv = '0; cyc(); cyc();

    // reset while ch3 holds the lock
    do_rst();
    mode = 1'b0; sel = 2'd3; iv = 4'b1000; il = '0; id = 32'h7700_0000;
    cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("mrst_ov", 32'(ov), 0);
    mode = 1'b1; iv = 4'b1001; il = 4'hF; id = 32'h7700_0055;
    cyc();
    chk("mrst_ch", 32'(och), 0);
    chk("mrst_od", 32'(od), 32'h55);
    iv = '0; cyc();

    // granted ch0 drops valid for two cycles mid-packet
    do_rst();
    mode = 1'b0; sel = 2'd0; iv = 4'b0001; il = '0; id = 32'h0000_0001;
    cyc();
    iv = 4'b0010; mode = 1'b1;
    cyc(); chk("gap_ov0", 32'(ov), 0);
    cyc(); chk("gap_ov1", 32'(ov), 0);
    iv = 4'b0011; il = 4'b0011; id = 32'h0000_0002;
    cyc();
    chk("gap_ch", 32'(och), 0);
    chk("gap_od", 32'(od), 32'h02);
    iv = '0; cyc();

    // 3-channel build: sel=3 selects nothing
    do_rst();
    mode = 1'b0; sel3 = 2'd3; iv3 = 3'b111; il3 = 3'b111; id3 = 24'h99_0000;
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk("n3_rdy", 32'(irdy3), 0);
      chk("n3_ov", 32'(ov3), 0);
    end
    sel3 = 2'd2;
    cyc();
    chk("n3_ch", 32'(och3), 2);
    chk("n3_od", 32'(od3), 32'h99);
    chk("n3_ov1", 32'(ov3), 1);
    iv3 = '0;

    // random traffic against the model
    do_rst();
    for (int r = 0; r < 3000; r++) begin
      rst  = ($urandom % 64) == 0;
      mode = 1'($urandom);
      sel  = 2'($urandom);
      iv   = 4'($urandom);
      il   = 4'($urandom & $urandom);
      id   = $urandom;
      ordy = ($urandom % 4) != 0;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
